hit_trg_rate_monitor: RTL and testbench
=======================================

HIT_TRG_RATE_MONITOR -- requirements
Module: hit_trg_rate_monitor

Interface
REQ-001 SHALL have parameter HIT_CH, default 8: number of hit channels; even, 2..32.
REQ-002 SHALL have parameter BUSY_CH, default 2: number of busy channels, 1..16.
REQ-003 SHALL have parameter HIT_CNT_W, default 32: hit monitor counter width.
REQ-004 SHALL have parameter CNT_W, default 16: busy and trigger counter width.
REQ-005 SHALL have parameter IDLE_WIN, default 4: consecutive zero-count windows that flag an idle error, 1..255.
REQ-006 SHALL define derived widths PSEL_W = max(1, clog2(HIT_CH/2)) and BSEL_W = max(1, clog2(BUSY_CH)).
REQ-007 SHALL have port clk_in, input, 1: single clock; all logic rises on it.
REQ-008 SHALL have port rst_n_in, input, 1: reset, asynchronous assert, active-low.
REQ-009 SHALL have port hit_syn_in, input, HIT_CH: synchronised hit lines.
REQ-010 SHALL have port busy_syn_in, input, BUSY_CH: synchronised busy lines.
REQ-011 SHALL have port update_end_in, input, 1: window boundary; its rising edge closes a window.
REQ-012 SHALL have ports eff_trg_in, coincid_trg_in, logic_match_in and ext_trg_syn_in, each input, 1: trigger event lines.
REQ-013 SHALL have port auto_sel_in, input, 1: 1 = rotate the monitor selection, 0 = use the fixed selection.
REQ-014 SHALL have ports hit_monit_fix_sel_in, input, PSEL_W, and busy_monit_fix_sel_in, input, BSEL_W: fixed pair and busy index.
REQ-015 SHALL have ports hit_monit_sel_out, output, PSEL_W, and busy_monit_sel_out, output, BSEL_W: selection in force for the current window.
REQ-016 SHALL have ports hit_monit_cnt_0_out and hit_monit_cnt_1_out, output, HIT_CNT_W each: latched counts of channels 2*sel and 2*sel+1.
REQ-017 SHALL have port busy_monit_cnt_out, output, CNT_W: latched count of the selected busy channel.
REQ-018 SHALL have ports eff_trg_cnt_out, coincid_trg_cnt_out, logic_match_cnt_out and ext_trg_cnt_out, output, CNT_W each: latched trigger counts.
REQ-019 SHALL have ports hit_monit_err_cnt_out and busy_monit_err_cnt_out, output, 8 each: cumulative idle-error counts.
REQ-020 SHALL have port trg_delay_timer_out, output, 8: last measured logic_match-to-eff_trg delay in cycles.
REQ-021 SHALL have port cnt_valid_out, output, 1: one-cycle pulse when the latched outputs change.

Function
REQ-022 SHALL define an event as a 0->1 transition of a line between consecutive clk_in samples, each line registered once.
REQ-023 SHALL keep the live counters for the two selected hit channels, the selected busy channel and the four triggers; each counter adds 1 per event.
REQ-024 SHALL saturate every live counter at its all-ones value, with no wrap.
REQ-025 SHALL define a window close as the cycle in which an update_end_in rising edge is detected.
REQ-026 SHALL, at a window close: copy every live counter to its _out register; reload each live counter with 1 if that line has an event in the same cycle, else 0; pulse cnt_valid_out high in the next cycle; the _out values change in that same cycle.
REQ-027 SHALL, at a window close in auto mode: advance the hit pair select by 1 modulo HIT_CH/2 and the busy select by 1 modulo BUSY_CH.
REQ-028 SHALL, at a window close in fixed mode: load both selects from the fix inputs.
REQ-029 SHALL, outside a window close, ignore selection changes and auto_sel_in changes until the next close.
REQ-030 SHALL keep a hit idle-run counter, 8-bit saturating: at each close, +1 if either monitored hit count is 0, else cleared.
REQ-031 SHALL, when the hit idle-run counter reaches IDLE_WIN: increment hit_monit_err_cnt_out, saturating at 255, and clear the run counter.
REQ-032 SHALL apply the REQ-030/REQ-031 rules identically to the busy channel, driving busy_monit_err_cnt_out.
REQ-033 SHALL clear both idle-run counters whenever the selection changes at a close.
REQ-034 SHALL implement the delay timer as a two-state FSM, IDLE and RUN.
REQ-035 SHALL transition IDLE->RUN on a logic_match event, clearing the timer to 0; in RUN the timer increments each cycle and saturates at 255.
REQ-036 SHALL transition RUN->IDLE on an eff_trg event, latching the timer value to trg_delay_timer_out.
REQ-037 SHALL restart the timer at 0 on a logic_match event while in RUN.
REQ-038 SHALL, when logic_match and eff_trg events occur in the same cycle, latch 0 and end in IDLE.
REQ-039 SHALL ignore an eff_trg event in IDLE for the timer; it is still counted.

Reset
REQ-040 SHALL, while rst_n_in=0: clear all counters, _out registers, selects, idle-run counters and edge-sample registers to 0, hold cnt_valid_out at 0 and the FSM in IDLE.
REQ-041 SHALL discard a window in progress when reset asserts mid-window; the first close after release latches only post-reset events.
REQ-042 SHALL not register a line held high at reset release as an event.

Verification
REQ-043 SHALL cover: auto mode, HIT_CH=8, 5 hit_syn_in[0] pulses and 3 hit_syn_in[1] pulses in a window -> after close, cnt_0=5, cnt_1=3, sel advances 0->1, cnt_valid_out pulses exactly once.
REQ-044 SHALL cover: a hit event in the same cycle as the update_end_in rising edge -> excluded from the closing window, next window's count = 1 + later events.
REQ-045 SHALL cover: fixed mode, sel=3, channel 7 silent for 4 windows with IDLE_WIN=4 -> hit_monit_err_cnt_out=1 after the 4th close, 2 after the 8th.
REQ-046 SHALL cover: CNT_W=4 with 20 eff_trg events in one window -> eff_trg_cnt_out=15.
REQ-047 SHALL cover: logic_match event then eff_trg event 37 cycles later -> trg_delay_timer_out=37; with a 300-cycle gap -> 255; with the same-cycle case -> 0.
REQ-048 SHALL cover: reset asserted mid-window after 10 events, then 2 events after release -> next close latches 2, all error counts 0.

Source files
------------

// File: rtl/hit_trg_rate_monitor.sv
// Windowed rate monitor: counts hit, busy and trigger events between update_end
// rising edges, flags persistently idle channels and measures logic_match->eff_trg delay.
module hit_trg_rate_monitor #(
  parameter int HIT_CH    = 8,
  parameter int BUSY_CH   = 2,
  parameter int HIT_CNT_W = 32,
  parameter int CNT_W     = 16,
  parameter int IDLE_WIN  = 4,
  localparam int PSEL_W   = (HIT_CH / 2 > 1) ? $clog2(HIT_CH / 2) : 1,
  localparam int BSEL_W   = (BUSY_CH > 1) ? $clog2(BUSY_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [HIT_CH-1:0]    hit_syn_in,
  input  logic [BUSY_CH-1:0]   busy_syn_in,
  input  logic                 update_end_in,
  input  logic                 eff_trg_in,
  input  logic                 coincid_trg_in,
  input  logic                 logic_match_in,
  input  logic                 ext_trg_syn_in,
  input  logic                 auto_sel_in,
  input  logic [PSEL_W-1:0]    hit_monit_fix_sel_in,
  input  logic [BSEL_W-1:0]    busy_monit_fix_sel_in,
  output logic [PSEL_W-1:0]    hit_monit_sel_out,
  output logic [BSEL_W-1:0]    busy_monit_sel_out,
  output logic [HIT_CNT_W-1:0] hit_monit_cnt_0_out,
  output logic [HIT_CNT_W-1:0] hit_monit_cnt_1_out,
  output logic [CNT_W-1:0]     busy_monit_cnt_out,
  output logic [CNT_W-1:0]     eff_trg_cnt_out,
  output logic [CNT_W-1:0]     coincid_trg_cnt_out,
  output logic [CNT_W-1:0]     logic_match_cnt_out,
  output logic [CNT_W-1:0]     ext_trg_cnt_out,
  output logic [7:0]           hit_monit_err_cnt_out,
  output logic [7:0]           busy_monit_err_cnt_out,
  output logic [7:0]           trg_delay_timer_out,
  output logic                 cnt_valid_out,
  output logic                 tmr_state_dbg_out
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} tmr_state_e;

  localparam int NPAIR = HIT_CH / 2;

  function automatic logic pick_hit(input logic [HIT_CH-1:0] v, input logic [PSEL_W-1:0] pair,
                                    input logic odd);
    logic [PSEL_W:0] idx;
    idx = {pair, odd};
    if (int'(idx) < HIT_CH) return v[idx];
    return 1'b0;
  endfunction

  function automatic logic pick_busy(input logic [BUSY_CH-1:0] v, input logic [BSEL_W-1:0] sel);
    if (int'(sel) < BUSY_CH) return v[sel];
    return 1'b0;
  endfunction

  // Edge samples; arm_q masks the first cycle after reset so lines already high are not events.
  logic                arm_q;
  logic [HIT_CH-1:0]   hit_q;
  logic [BUSY_CH-1:0]  busy_q;
  logic                upd_q;
  logic [3:0]          trg_q;
  logic [3:0]          trg_in;
  logic [HIT_CH-1:0]   hit_ev;
  logic [BUSY_CH-1:0]  busy_ev;
  logic [3:0]          trg_ev;
  logic                close;

  logic [PSEL_W-1:0]   hsel_q, hsel_d;
  logic [BSEL_W-1:0]   bsel_q, bsel_d;
  logic                sel_chg;

  logic [1:0][HIT_CNT_W-1:0] hit_live_q, hit_live_d, hit_out_q;
  logic [1:0]                hit_ev_cur, hit_ev_new;
  logic [CNT_W-1:0]          busy_live_q, busy_live_d, busy_out_q;
  logic                      busy_ev_cur, busy_ev_new;
  logic [3:0][CNT_W-1:0]     trg_live_q, trg_live_d, trg_out_q;

  logic [7:0] hrun_q, hrun_d, hrun_inc, herr_q, herr_d;
  logic [7:0] brun_q, brun_d, brun_inc, berr_q, berr_d;
  logic       hrun_hit, brun_hit;
  logic       valid_q;

  tmr_state_e state_q, state_d;
  logic [7:0] timer_q, timer_d, timer_inc, delay_q, delay_d;

  assign trg_in  = {ext_trg_syn_in, logic_match_in, coincid_trg_in, eff_trg_in};
  assign hit_ev  = hit_syn_in & ~hit_q & {HIT_CH{arm_q}};
  assign busy_ev = busy_syn_in & ~busy_q & {BUSY_CH{arm_q}};
  assign trg_ev  = trg_in & ~trg_q & {4{arm_q}};
  assign close   = update_end_in & ~upd_q & arm_q;

  always_comb begin
    hsel_d = hsel_q;
    bsel_d = bsel_q;
    if (close) begin
      if (auto_sel_in) begin
        hsel_d = (int'(hsel_q) >= NPAIR - 1) ? '0 : hsel_q + PSEL_W'(1);
        bsel_d = (int'(bsel_q) >= BUSY_CH - 1) ? '0 : bsel_q + BSEL_W'(1);
      end else begin
        hsel_d = hit_monit_fix_sel_in;
        bsel_d = busy_monit_fix_sel_in;
      end
    end
  end

  assign sel_chg = (hsel_d != hsel_q) || (bsel_d != bsel_q);

  // A close reloads from events on the channels selected for the window that starts now.
  always_comb begin
    hit_ev_cur[0] = pick_hit(hit_ev, hsel_q, 1'b0);
    hit_ev_cur[1] = pick_hit(hit_ev, hsel_q, 1'b1);
    hit_ev_new[0] = pick_hit(hit_ev, hsel_d, 1'b0);
    hit_ev_new[1] = pick_hit(hit_ev, hsel_d, 1'b1);
    busy_ev_cur   = pick_busy(busy_ev, bsel_q);
    busy_ev_new   = pick_busy(busy_ev, bsel_d);
    hit_live_d    = hit_live_q;
    busy_live_d   = busy_live_q;
    trg_live_d    = trg_live_q;
    for (int i = 0; i < 2; i++) begin
      if (close) hit_live_d[i] = HIT_CNT_W'(hit_ev_new[i]);
      else if (hit_ev_cur[i] && hit_live_q[i] != '1) hit_live_d[i] = hit_live_q[i] + HIT_CNT_W'(1);
    end
    if (close) busy_live_d = CNT_W'(busy_ev_new);
    else if (busy_ev_cur && busy_live_q != '1) busy_live_d = busy_live_q + CNT_W'(1);
    for (int t = 0; t < 4; t++) begin
      if (close) trg_live_d[t] = CNT_W'(trg_ev[t]);
      else if (trg_ev[t] && trg_live_q[t] != '1) trg_live_d[t] = trg_live_q[t] + CNT_W'(1);
    end
  end

  always_comb begin
    hrun_inc = '0;
    brun_inc = '0;
    if (hit_live_q[0] == '0 || hit_live_q[1] == '0)
      hrun_inc = (hrun_q == 8'hFF) ? hrun_q : hrun_q + 8'd1;
    if (busy_live_q == '0)
      brun_inc = (brun_q == 8'hFF) ? brun_q : brun_q + 8'd1;
    hrun_hit = close && (hrun_inc == 8'(IDLE_WIN));
    brun_hit = close && (brun_inc == 8'(IDLE_WIN));
    hrun_d   = hrun_q;
    brun_d   = brun_q;
    herr_d   = herr_q;
    berr_d   = berr_q;
    if (close) begin
      hrun_d = (sel_chg || hrun_hit) ? 8'd0 : hrun_inc;
      brun_d = (sel_chg || brun_hit) ? 8'd0 : brun_inc;
      if (hrun_hit && herr_q != 8'hFF) herr_d = herr_q + 8'd1;
      if (brun_hit && berr_q != 8'hFF) berr_d = berr_q + 8'd1;
    end
  end

  // The latched delay is the event-to-event cycle distance, i.e. the count including this cycle.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    delay_d   = delay_q;
    timer_inc = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    case (state_q)
      ST_IDLE: begin
        if (trg_ev[2] && trg_ev[0]) begin
          delay_d = 8'd0;
        end else if (trg_ev[2]) begin
          state_d = ST_RUN;
          timer_d = 8'd0;
        end
      end
      ST_RUN: begin
        timer_d = timer_inc;
        if (trg_ev[2] && trg_ev[0]) begin
          delay_d = 8'd0;
          timer_d = 8'd0;
          state_d = ST_IDLE;
        end else if (trg_ev[2]) begin
          timer_d = 8'd0;
        end else if (trg_ev[0]) begin
          delay_d = timer_inc;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      arm_q       <= 1'b0;
      hit_q       <= '0;
      busy_q      <= '0;
      upd_q       <= 1'b0;
      trg_q       <= '0;
      hsel_q      <= '0;
      bsel_q      <= '0;
      hit_live_q  <= '0;
      hit_out_q   <= '0;
      busy_live_q <= '0;
      busy_out_q  <= '0;
      trg_live_q  <= '0;
      trg_out_q   <= '0;
      hrun_q      <= '0;
      brun_q      <= '0;
      herr_q      <= '0;
      berr_q      <= '0;
      valid_q     <= 1'b0;
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      delay_q     <= '0;
    end else begin
      arm_q       <= 1'b1;
      hit_q       <= hit_syn_in;
      busy_q      <= busy_syn_in;
      upd_q       <= update_end_in;
      trg_q       <= trg_in;
      hsel_q      <= hsel_d;
      bsel_q      <= bsel_d;
      hit_live_q  <= hit_live_d;
      busy_live_q <= busy_live_d;
      trg_live_q  <= trg_live_d;
      hrun_q      <= hrun_d;
      brun_q      <= brun_d;
      herr_q      <= herr_d;
      berr_q      <= berr_d;
      valid_q     <= close;
      state_q     <= state_d;
      timer_q     <= timer_d;
      delay_q     <= delay_d;
      if (close) begin
        hit_out_q  <= hit_live_q;
        busy_out_q <= busy_live_q;
        trg_out_q  <= trg_live_q;
      end
    end
  end

  assign hit_monit_sel_out      = hsel_q;
  assign busy_monit_sel_out     = bsel_q;
  assign hit_monit_cnt_0_out    = hit_out_q[0];
  assign hit_monit_cnt_1_out    = hit_out_q[1];
  assign busy_monit_cnt_out     = busy_out_q;
  assign eff_trg_cnt_out        = trg_out_q[0];
  assign coincid_trg_cnt_out    = trg_out_q[1];
  assign logic_match_cnt_out    = trg_out_q[2];
  assign ext_trg_cnt_out        = trg_out_q[3];
  assign hit_monit_err_cnt_out  = herr_q;
  assign busy_monit_err_cnt_out = berr_q;
  assign trg_delay_timer_out    = delay_q;
  assign cnt_valid_out          = valid_q;
  assign tmr_state_dbg_out      = state_q;

endmodule

// File: tb/tb_hit_trg_rate_monitor.sv
// Bench for hit_trg_rate_monitor: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a window-level reference model.
module tb_hit_trg_rate_monitor;
  localparam int HIT_CH = 8, BUSY_CH = 2, HIT_CNT_W = 6, CNT_W = 4, IDLE_WIN = 4;
  localparam int PSEL_W = 2, BSEL_W = 1, NPAIR = HIT_CH / 2;
  localparam int HMAX = (1 << HIT_CNT_W) - 1, CMAX = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [HIT_CH-1:0]    hit_syn = '0;
  logic [BUSY_CH-1:0]   busy_syn = '0;
  logic                 upd = 0, eff = 0, coin = 0, lm = 0, ext = 0, auto_sel = 0;
  logic [PSEL_W-1:0]    hfix = '0;
  logic [BSEL_W-1:0]    bfix = '0;
  logic [PSEL_W-1:0]    hsel_o;
  logic [BSEL_W-1:0]    bsel_o;
  logic [HIT_CNT_W-1:0] hcnt0, hcnt1;
  logic [CNT_W-1:0]     bcnt, eff_cnt, coin_cnt, lm_cnt, ext_cnt;
  logic [7:0]           herr, berr, delay;
  logic                 valid, dbg_state;

  hit_trg_rate_monitor #(.HIT_CH(HIT_CH), .BUSY_CH(BUSY_CH), .HIT_CNT_W(HIT_CNT_W),
                         .CNT_W(CNT_W), .IDLE_WIN(IDLE_WIN)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .hit_syn_in(hit_syn), .busy_syn_in(busy_syn),
    .update_end_in(upd), .eff_trg_in(eff), .coincid_trg_in(coin), .logic_match_in(lm),
    .ext_trg_syn_in(ext), .auto_sel_in(auto_sel), .hit_monit_fix_sel_in(hfix),
    .busy_monit_fix_sel_in(bfix), .hit_monit_sel_out(hsel_o), .busy_monit_sel_out(bsel_o),
    .hit_monit_cnt_0_out(hcnt0), .hit_monit_cnt_1_out(hcnt1), .busy_monit_cnt_out(bcnt),
    .eff_trg_cnt_out(eff_cnt), .coincid_trg_cnt_out(coin_cnt), .logic_match_cnt_out(lm_cnt),
    .ext_trg_cnt_out(ext_cnt), .hit_monit_err_cnt_out(herr), .busy_monit_err_cnt_out(berr),
    .trg_delay_timer_out(delay), .cnt_valid_out(valid), .tmr_state_dbg_out(dbg_state)
  );

  int vectors = 0, miscompares = 0, vcount = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: per-channel event tallies for the open window, whole-window bookkeeping at closes.
  bit                 m_armed, m_uprev, m_running, m_valid;
  logic [HIT_CH-1:0]  m_hprev;
  logic [BUSY_CH-1:0] m_bprev;
  logic [3:0]         m_tprev;
  int m_hwin[HIT_CH], m_bwin[BUSY_CH], m_twin[4], m_t[4];
  int m_hsel, m_bsel, m_h0, m_h1, m_b, m_hrun, m_brun, m_herr, m_berr, m_delay, m_start, m_cyc;

  task automatic model_step();
    logic [3:0] trg_now, tev;
    logic [HIT_CH-1:0] hev;
    logic [BUSY_CH-1:0] bev;
    int hinc, binc, nh, nb;
    bit hhit, bhit, chg;
    trg_now = {ext, lm, coin, eff};
    m_valid = 0;
    if (!rst_n) begin
      m_armed = 0; m_hprev = '0; m_bprev = '0; m_tprev = '0; m_uprev = 0;
      m_hsel = 0; m_bsel = 0; m_h0 = 0; m_h1 = 0; m_b = 0;
      m_hrun = 0; m_brun = 0; m_herr = 0; m_berr = 0; m_delay = 0; m_running = 0;
      for (int i = 0; i < HIT_CH; i++) m_hwin[i] = 0;
      for (int i = 0; i < BUSY_CH; i++) m_bwin[i] = 0;
      for (int i = 0; i < 4; i++) begin m_twin[i] = 0; m_t[i] = 0; end
    end else if (!m_armed) begin
      m_armed = 1; m_hprev = hit_syn; m_bprev = busy_syn; m_tprev = trg_now; m_uprev = upd;
    end else begin
      hev = hit_syn & ~m_hprev;
      bev = busy_syn & ~m_bprev;
      tev = trg_now & ~m_tprev;
      if (upd && !m_uprev) begin
        m_valid = 1;
        m_h0 = m_hwin[2 * m_hsel];
        m_h1 = m_hwin[2 * m_hsel + 1];
        m_b  = m_bwin[m_bsel];
        for (int i = 0; i < 4; i++) m_t[i] = m_twin[i];
        hinc = (m_h0 == 0 || m_h1 == 0) ? imin(m_hrun + 1, 255) : 0;
        binc = (m_b == 0) ? imin(m_brun + 1, 255) : 0;
        hhit = (hinc == IDLE_WIN);
        bhit = (binc == IDLE_WIN);
        if (hhit) m_herr = imin(m_herr + 1, 255);
        if (bhit) m_berr = imin(m_berr + 1, 255);
        if (auto_sel) begin nh = (m_hsel + 1) % NPAIR; nb = (m_bsel + 1) % BUSY_CH; end
        else begin nh = int'(hfix); nb = int'(bfix); end
        chg = (nh != m_hsel) || (nb != m_bsel);
        m_hrun = (chg || hhit) ? 0 : hinc;
        m_brun = (chg || bhit) ? 0 : binc;
        m_hsel = nh; m_bsel = nb;
        for (int i = 0; i < HIT_CH; i++) m_hwin[i] = int'(hev[i]);
        for (int i = 0; i < BUSY_CH; i++) m_bwin[i] = int'(bev[i]);
        for (int i = 0; i < 4; i++) m_twin[i] = int'(tev[i]);
      end else begin
        for (int i = 0; i < HIT_CH; i++) m_hwin[i] = imin(m_hwin[i] + int'(hev[i]), HMAX);
        for (int i = 0; i < BUSY_CH; i++) m_bwin[i] = imin(m_bwin[i] + int'(bev[i]), CMAX);
        for (int i = 0; i < 4; i++) m_twin[i] = imin(m_twin[i] + int'(tev[i]), CMAX);
      end
      if (tev[2] && tev[0]) begin m_delay = 0; m_running = 0; end
      else if (tev[2]) begin m_running = 1; m_start = m_cyc; end
      else if (tev[0] && m_running) begin m_delay = imin(m_cyc - m_start, 255); m_running = 0; end
      m_hprev = hit_syn; m_bprev = busy_syn; m_tprev = trg_now; m_uprev = upd;
    end
    m_cyc++;
  endtask

  // scoreboard: model advances on each edge, DUT compared 1 time unit later
  always @(posedge clk) begin
    model_step();
    #1;
    check("hit_sel", hsel_o, m_hsel);
    check("busy_sel", bsel_o, m_bsel);
    check("hit_cnt_0", hcnt0, m_h0);
    check("hit_cnt_1", hcnt1, m_h1);
    check("busy_cnt", bcnt, m_b);
    check("eff_cnt", eff_cnt, m_t[0]);
    check("coin_cnt", coin_cnt, m_t[1]);
    check("lm_cnt", lm_cnt, m_t[2]);
    check("ext_cnt", ext_cnt, m_t[3]);
    check("hit_err", herr, m_herr);
    check("busy_err", berr, m_berr);
    check("delay", delay, m_delay);
    check("cnt_valid", valid, m_valid);
    check("tmr_running", dbg_state, m_running);
    if (valid) vcount++;
  end

  // driver tasks (inputs change on the falling edge)
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_hit(input int ch);
    hit_syn[ch] = 1'b1; step(1); hit_syn[ch] = 1'b0; step(1);
  endtask

  task automatic pulse_eff();
    eff = 1'b1; step(1); eff = 1'b0; step(1);
  endtask

  task automatic close_win();
    upd = 1'b1; step(1); upd = 1'b0; step(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(2); rst_n = 1'b1; step(2);
  endtask

  task automatic delay_test(input int gap, input int exp);
    lm = 1'b1; step(1); lm = 1'b0;
    step(gap - 1);
    eff = 1'b1; step(1); eff = 1'b0; step(2);
    check("delay_lit", delay, exp);
    check("model_delay_lit", m_delay, exp);
  endtask

  initial begin
    auto_sel = 1'b1;
    step(3);
    check("reset_hit_cnt_0", hcnt0, 0);
    check("reset_valid", valid, 0);
    rst_n = 1'b1; step(2);

    // auto mode, 5 + 3 hits in one window
    vcount = 0;
    repeat (3) begin
      hit_syn[1:0] = 2'b11; step(1); hit_syn[1:0] = 2'b00; step(1);
    end
    pulse_hit(0); pulse_hit(0);
    close_win(); step(3);
    check("a_cnt_0", hcnt0, 5);
    check("a_cnt_1", hcnt1, 3);
    check("model_a_cnt_0", m_h0, 5);
    check("a_sel", hsel_o, 1);
    check("a_valid_pulses", vcount, 1);

    // hit coincident with the closing edge belongs to the next window
    auto_sel = 1'b0; hfix = 2'd0;
    close_win();
    hit_syn[0] = 1'b1; upd = 1'b1; step(1); hit_syn[0] = 1'b0; upd = 1'b0; step(2);
    check("b_close_cnt_0", hcnt0, 0);
    pulse_hit(0); pulse_hit(0);
    close_win();
    check("b_next_cnt_0", hcnt0, 3);

    // fixed pair 3 with channel 7 silent
    do_reset();
    hfix = 2'd3; bfix = 1'b0;
    close_win();
    check("c_sel", hsel_o, 3);
    for (int w = 1; w <= 8; w++) begin
      pulse_hit(6);
      busy_syn[0] = 1'b1; step(1); busy_syn[0] = 1'b0; step(1);
      close_win();
      if (w == 4) check("c_err_after_4", herr, 1);
      if (w == 8) check("c_err_after_8", herr, 2);
    end
    check("model_c_err", m_herr, 2);
    check("c_busy_err", berr, 0);

    // trigger counter saturation
    repeat (20) pulse_eff();
    close_win();
    check("d_eff_sat", eff_cnt, 15);

    // delay timer
    delay_test(37, 37);
    delay_test(300, 255);
    lm = 1'b1; eff = 1'b1; step(1); lm = 1'b0; eff = 1'b0; step(2);
    check("e_same_cycle", delay, 0);

    // reset mid-window; eff held high across release is not an event
    repeat (10) pulse_eff();
    rst_n = 1'b0; eff = 1'b1; step(1);
    check("f_in_reset_eff", eff_cnt, 0);
    step(1); rst_n = 1'b1; step(2); eff = 1'b0; step(1);
    pulse_eff(); pulse_eff();
    close_win();
    check("f_eff_post_reset", eff_cnt, 2);
    check("f_hit_err", herr, 0);
    check("f_busy_err", berr, 0);

    // randomized traffic: short windows, long (saturating) windows, sparse hits
    for (int c = 0; c < 4500; c++) begin
      int phase;
      phase = c / 1500;
      hit_syn  = (phase == 2) ? HIT_CH'($urandom & $urandom & $urandom) : HIT_CH'($urandom);
      busy_syn = (phase == 2) ? BUSY_CH'($urandom & $urandom) : BUSY_CH'($urandom);
      upd  = (phase == 1) ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 19) == 0);
      lm   = ($urandom_range(0, 39) == 0);
      eff  = ($urandom_range(0, 29) == 0);
      coin = 1'($urandom_range(0, 1));
      ext  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) auto_sel = ~auto_sel;
      if ($urandom_range(0, 149) == 0) hfix = PSEL_W'($urandom);
      if ($urandom_range(0, 149) == 0) bfix = BSEL_W'($urandom);
      rst_n = ($urandom_range(0, 999) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
